// File: rtl/period_meter_pkg.sv
// ============================================================================
// period_meter_pkg : shared state encoding and default sizing for period_meter
// Revision 1.0
// ============================================================================
`default_nettype none

package period_meter_pkg;

    localparam int DEFAULT_CNT_W          = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 30000000;

    typedef enum logic [0:0] {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/period_meter_sync_edge_detect.sv
// ============================================================================
// sync_edge_detect : multi-flop synchronizer with a registered rising-edge pulse
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic level_out,
    output logic rise_out
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync     <= '0;
            sync_d   <= 1'b0;
            rise_out <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], async_in};
            sync_d   <= sync[SYNC_STAGES-1];
            // Registered so the pulse lands SYNC_STAGES+1 cycles after the pin edge.
            rise_out <= sync[SYNC_STAGES-1] & ~sync_d;
        end
    end

    assign level_out = sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/period_meter.sv
// ============================================================================
// period_meter : counts clk_in cycles between rising edges of sig_in, with
//                valid/ready result, overrun flag and stall timeout.
//                Optional high-time output: PERIOD_METER_HIGH_TIME_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module period_meter
    import period_meter_pkg::*;
#(
    parameter int CLOCK_MHZ      = 12,
    parameter int CNT_W          = DEFAULT_CNT_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun,
    output logic             stalled
`ifdef PERIOD_METER_HIGH_TIME_EN
    ,
    output logic [CNT_W-1:0] high_out
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    if (SYNC_STAGES < 2 || CLOCK_MHZ < 1 || TIMEOUT_CYCLES < 1 ||
        (CNT_W < 31 && TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_params
        $error("period_meter: illegal parameter set");
    end

    logic level;
    logic rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .async_in (sig_in),
        .level_out(level),
        .rise_out (rise)
    );

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             capture;
    logic             timeout;
    logic             transfer;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state <= WAIT_EDGE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            WAIT_EDGE: begin
                if (rise) begin
                    count_next = ONE;
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture    = 1'b1;
                    count_next = ONE;
                end else if (count == TIMEOUT_VAL) begin
                    timeout    = 1'b1;
                    count_next = '0;
                    state_next = WAIT_EDGE;
                end else begin
                    count_next = count + ONE;
                end
            end
            default: state_next = WAIT_EDGE;
        endcase
    end

    assign transfer = period_valid & period_ready;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            period_out   <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            if (capture) begin
                period_out   <= count;
                period_valid <= 1'b1;
                stalled      <= 1'b0;
            end else if (transfer) begin
                period_valid <= 1'b0;
            end
            if (timeout) begin
                stalled <= 1'b1;
            end
            // A same-cycle transfer consumes the old result, so it is not lost.
            if (transfer) begin
                overrun <= 1'b0;
            end else if (capture && period_valid) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef PERIOD_METER_HIGH_TIME_EN
    logic [CNT_W-1:0] high_count, high_count_next;

    always_comb begin
        high_count_next = high_count;
        if (state == WAIT_EDGE) begin
            if (rise) begin
                high_count_next = CNT_W'(level);
            end
        end else if (rise) begin
            high_count_next = CNT_W'(level);
        end else if (timeout) begin
            high_count_next = '0;
        end else begin
            high_count_next = high_count + CNT_W'(level);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            high_count <= '0;
            high_out   <= '0;
        end else begin
            high_count <= high_count_next;
            if (capture) begin
                high_out <= high_count;
            end
        end
    end
`else
    logic unused_level;
    assign unused_level = level;
`endif

endmodule

`default_nettype wire
